// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter
//  Purpose  : Round-robin sharing of one registered adder (1-cycle latency)
//             among NUM_REQ requesters. The operation is tagged and the result
//             is returned to its owner in the cycle after the grant.
//  Options  : ADDER_ARB_LOCK_EN adds lock_i. A requester that holds lock_i
//             keeps the grant for up to LOCK_MAX consecutive cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH_SUM = 20,
    parameter  int LOCK_MAX       = 8,
    localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH_SUM-1:0]   req_summand_1_i,
    input  logic [NUM_REQ*DATA_WIDTH_SUM-1:0]   req_summand_2_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic                                adder_en_o,
    output logic [DATA_WIDTH_SUM-1:0]           adder_summand_1_o,
    output logic [DATA_WIDTH_SUM-1:0]           adder_summand_2_o,
    input  logic [DATA_WIDTH_SUM-1:0]           adder_sum_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [ID_WIDTH-1:0]                 rsp_id_o,
    output logic [DATA_WIDTH_SUM-1:0]           rsp_sum_o,
`ifdef ADDER_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                  lock_i,
`endif
    output logic [15:0]                         busy_cnt_o
);

    localparam logic [ID_WIDTH-1:0] C_LAST_ID  = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [15:0]         C_BUSY_MAX = 16'hFFFF;

    // Unpacked views of the flattened request buses
    logic [DATA_WIDTH_SUM-1:0] w_summand_1 [NUM_REQ];
    logic [DATA_WIDTH_SUM-1:0] w_summand_2 [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_summand_1[gi] = req_summand_1_i[gi*DATA_WIDTH_SUM +: DATA_WIDTH_SUM];
            assign w_summand_2[gi] = req_summand_2_i[gi*DATA_WIDTH_SUM +: DATA_WIDTH_SUM];
        end
    endgenerate

    logic [ID_WIDTH-1:0] ptr_q,       ptr_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0] rsp_id_q,    rsp_id_d;
    logic [15:0]         busy_cnt_q,  busy_cnt_d;

    logic                w_grant;
    logic [ID_WIDTH-1:0] w_grant_idx;
    logic                w_lock_hit;

`ifdef ADDER_ARB_LOCK_EN
    localparam int LOCK_CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

    // Pick the first valid requester at or after the pointer; a lock can override
    always_comb begin
        int                  cand;
        logic [ID_WIDTH-1:0] cand_id;
        cand        = 0;
        cand_id     = '0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_lock_hit  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand    = (int'(ptr_q) + i) % NUM_REQ;
            cand_id = ID_WIDTH'(cand);
            if (!w_grant && req_valid_i[cand_id]) begin
                w_grant     = 1'b1;
                w_grant_idx = cand_id;
            end
        end
`ifdef ADDER_ARB_LOCK_EN
        // rsp_valid_q is the one-hot record of last cycle's grant. The lock is
        // honoured only while fewer than LOCK_MAX consecutive grants have occurred.
        if (rsp_valid_q[rsp_id_q] && lock_i[rsp_id_q] && req_valid_i[rsp_id_q] &&
            ((LOCK_CNT_W+1)'(lock_cnt_q) + 1'b1 < (LOCK_CNT_W+1)'(LOCK_MAX))) begin
            w_lock_hit  = 1'b1;
            w_grant     = 1'b1;
            w_grant_idx = rsp_id_q;
        end
`endif
        // No grant may be issued while reset is held
        if (rst_i) begin
            w_grant    = 1'b0;
            w_lock_hit = 1'b0;
        end
    end

    // Grant and adder-operand outputs
    always_comb begin
        req_ready_o       = '0;
        adder_en_o        = w_grant;
        adder_summand_1_o = '0;
        adder_summand_2_o = '0;
        if (w_grant) begin
            req_ready_o       = NUM_REQ'(1) << w_grant_idx;
            adder_summand_1_o = w_summand_1[w_grant_idx];
            adder_summand_2_o = w_summand_2[w_grant_idx];
        end
    end

    // Next-state: pointer advance, response tag, busy counter, lock counter
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = req_ready_o;
        rsp_id_d    = rsp_id_q;
        busy_cnt_d  = busy_cnt_q;
        if (w_grant) begin
            rsp_id_d = w_grant_idx;
            if (!w_lock_hit) begin
                ptr_d = (w_grant_idx == C_LAST_ID) ? '0 : w_grant_idx + 1'b1;
            end
            if (busy_cnt_q != C_BUSY_MAX) begin
                busy_cnt_d = busy_cnt_q + 16'd1;
            end
        end
`ifdef ADDER_ARB_LOCK_EN
        lock_cnt_d = w_lock_hit ? lock_cnt_q + 1'b1 : '0;
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            busy_cnt_q  <= '0;
`ifdef ADDER_ARB_LOCK_EN
            lock_cnt_q  <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            busy_cnt_q  <= busy_cnt_d;
`ifdef ADDER_ARB_LOCK_EN
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sum_o   = adder_sum_i;
    assign busy_cnt_o  = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_arbiter
//  Purpose  : Directed self-checking bench for adder_arbiter with a local
//             registered adder model (1-cycle latency, holds when idle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] s1_bus, s2_bus;
    logic [NREQ-1:0]   req_ready;
    logic              adder_en;
    logic [W-1:0]      adder_s1, adder_s2;
    logic [W-1:0]      adder_sum = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [15:0]       busy_cnt;
`ifdef ADDER_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared adder: registered sum, holds while enable is low
    always_ff @(posedge clk) begin
        if (adder_en) adder_sum <= adder_s1 + adder_s2;
    end

    adder_arbiter #(
        .NUM_REQ        (NREQ),
        .DATA_WIDTH_SUM (W),
        .LOCK_MAX       (3)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_summand_1_i   (s1_bus),
        .req_summand_2_i   (s2_bus),
        .req_ready_o       (req_ready),
        .adder_en_o        (adder_en),
        .adder_summand_1_o (adder_s1),
        .adder_summand_2_o (adder_s2),
        .adder_sum_i       (adder_sum),
        .rsp_valid_o       (rsp_valid),
        .rsp_id_o          (rsp_id),
        .rsp_sum_o         (rsp_sum),
`ifdef ADDER_ARB_LOCK_EN
        .lock_i            (lock),
`endif
        .busy_cnt_o        (busy_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sum(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
        s1_bus[n*W +: W] = a;
        s2_bus[n*W +: W] = b;
    endtask

    logic [3:0]  exp_rr   [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0]  exp_id   [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [19:0] exp_sum  [4] = '{20'd1001, 20'd2002, 20'd3003, 20'd4004};
    logic [3:0]  exp_wrap [4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
    logic [3:0]  exp_lock [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                  4'b0001, 4'b0001, 4'b0001, 4'b0010};

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        s1_bus    = '0;
        s2_bus    = '0;
`ifdef ADDER_ARB_LOCK_EN
        lock      = '0;
`endif
        // Reset: no grant while rst is high, clean state afterwards
        #2;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_en", 32'(adder_en), 32'h0);
        cyc();
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_busy", 32'(busy_cnt), 32'h0);
        rst       = 1'b0;
        req_valid = 4'b0000;

        // Single request from requester 2: 100 + (-30) = 70
        set_sum(2, 20'd100, 20'hFFFE2);
        req_valid = 4'b0100;
        #4;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_en", 32'(adder_en), 32'h1);
        check("single_s1", 32'(adder_s1), 32'd100);
        check("single_s2", 32'(adder_s2), 32'hFFFE2);
        cyc();
        req_valid = 4'b0000;
        check("single_rsp_valid", 32'(rsp_valid), 32'h4);
        check("single_rsp_id", 32'(rsp_id), 32'd2);
        check("single_rsp_sum", 32'(rsp_sum), 32'd70);
        #4;
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_en", 32'(adder_en), 32'h0);
        check("idle_s1", 32'(adder_s1), 32'h0);
        cyc();
        // Pointer now at 3: with all valid, requester 3 wins
        req_valid = 4'b1111;
        #4;
        check("ptr3_ready", 32'(req_ready), 32'h8);
        cyc();
        req_valid = 4'b0000;
        check("busy_two", 32'(busy_cnt), 32'd2);

        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // All requesters valid for 8 cycles
        for (int n = 0; n < NREQ; n++) set_sum(n, W'(1000 * (n + 1)), W'(n + 1));
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #4;
            check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(exp_rr[i]));
            cyc();
            check($sformatf("rr_rsp_valid_%0d", i), 32'(rsp_valid), 32'(exp_rr[i]));
            check($sformatf("rr_rsp_id_%0d", i), 32'(rsp_id), 32'(exp_id[i]));
            check($sformatf("rr_rsp_sum_%0d", i), 32'(rsp_sum), 32'(exp_sum[exp_id[i]]));
        end
        req_valid = 4'b0000;
        check("rr_busy", 32'(busy_cnt), 32'd8);

        // Wrap: steer pointer to 3, then alternate between 3 and 0
        req_valid = 4'b1000;
        #4;
        check("steer_a", 32'(req_ready), 32'h8);
        cyc();
        req_valid = 4'b0100;
        #4;
        check("steer_b", 32'(req_ready), 32'h4);
        cyc();
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #4;
            check($sformatf("wrap_ready_%0d", i), 32'(req_ready), 32'(exp_wrap[i]));
            cyc();
        end
        req_valid = 4'b0000;

        // Overflow wraps: 0x7FFFF + 1 = 0x80000
        set_sum(0, 20'h7FFFF, 20'h00001);
        req_valid = 4'b0001;
        #4;
        check("ovf_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        check("ovf_rsp_valid", 32'(rsp_valid), 32'h1);
        check("ovf_rsp_sum", 32'(rsp_sum), 32'h80000);

        // Reset mid-operation discards the in-flight response
        req_valid = 4'b0010;
        #4;
        check("mid_ready", 32'(req_ready), 32'h2);
        cyc();
        rst       = 1'b1;
        req_valid = 4'b1111;
        #4;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_en", 32'(adder_en), 32'h0);
        check("mid_rsp_pending", 32'(rsp_valid), 32'h2);
        cyc();
        check("mid_rsp_dropped", 32'(rsp_valid), 32'h0);
        check("mid_busy", 32'(busy_cnt), 32'h0);
        rst = 1'b0;
        #4;
        check("post_rst_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        check("post_rst_rsp_id", 32'(rsp_id), 32'd0);

        // Withdrawn request: no grant, no response
        req_valid = 4'b0100;
        #1;
        req_valid = 4'b0000;
        #3;
        check("withdraw_ready", 32'(req_ready), 32'h0);
        cyc();
        check("withdraw_rsp", 32'(rsp_valid), 32'h0);

`ifdef ADDER_ARB_LOCK_EN
        // Lock held by requester 0 with LOCK_MAX=3
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 4'b0011;
        lock      = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #4;
            check($sformatf("lock_ready_%0d", i), 32'(req_ready), 32'(exp_lock[i]));
            cyc();
        end
        req_valid = 4'b0000;
        lock      = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one registered `adder` instance (1-cycle latency, holds its output while its enable is low) among NUM_REQ requesters, e.g. the PE partial-sum units in one cluster.
- Each cycle it picks at most one valid requester by round-robin and muxes that requester's summands onto the adder inputs.
- It tags the in-flight operation and returns the adder result to the owning requester in the following cycle.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- DATA_WIDTH_SUM, 20: summand/sum width; must equal the adder's DATA_WIDTH_SUM.
- ID_WIDTH, $clog2(NUM_REQ): width of requester index; derived, not overridden.
- LOCK_MAX, 8: maximum consecutive locked grants (used only with ADDER_ARB_LOCK_EN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_summand_1_i  in  NUM_REQ*DATA_WIDTH_SUM  flattened first summands; requester n occupies slice [n*W +: W].
- req_summand_2_i  in  NUM_REQ*DATA_WIDTH_SUM  flattened second summands; same slicing.
- req_ready_o  out  NUM_REQ  one-hot grant; request consumed in the cycle it is high.
- adder_en_o  out  1  to adder adder_en_i.
- adder_summand_1_o  out  DATA_WIDTH_SUM  to adder summand_1_i.
- adder_summand_2_o  out  DATA_WIDTH_SUM  to adder summand_2_i.
- adder_sum_i  in  DATA_WIDTH_SUM  from adder sum_o.
- rsp_valid_o  out  NUM_REQ  one-hot: result for requester n valid this cycle.
- rsp_id_o  out  ID_WIDTH  index of the requester owning the current response.
- rsp_sum_o  out  DATA_WIDTH_SUM  result; equals adder_sum_i.
- busy_cnt_o  out  16  saturating count of granted cycles since reset.
- lock_i  in  NUM_REQ  per-requester lock request; present only with ADDER_ARB_LOCK_EN.

Behaviour:
- State:
  - ptr_q (ID_WIDTH): round-robin priority pointer.
  - rsp_valid_q (NUM_REQ): response tag valid.
  - rsp_id_q (ID_WIDTH): response tag index.
  - busy_cnt_q (16): busy counter.
- Reset (rst_i=1 at a clock edge):
  - ptr_q=0, rsp_valid_q=0, rsp_id_q=0, busy_cnt_q=0.
  - While rst_i is high, req_ready_o=0 and adder_en_o=0 combinationally; no grant is issued.
  - An in-flight response is discarded: rsp_valid_o=0 from the cycle after the reset edge.
- Arbitration (combinational):
  - Search req_valid_i starting at index ptr_q, wrapping NUM_REQ-1 -> 0.
  - The first set bit k is granted: req_ready_o=(1<<k), adder_en_o=1.
  - adder_summand_1/2_o = slice k of the request buses.
  - No valid request: req_ready_o=0, adder_en_o=0, summand outputs=0.
- Pointer update: grant to k -> ptr_q <= (k+1) mod NUM_REQ. No grant -> ptr_q holds.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles between grants.
- Response tagging:
  - rsp_valid_q <= req_ready_o; rsp_id_q <= k on a grant; rsp_id_q holds otherwise.
  - rsp_valid_o=rsp_valid_q, rsp_id_o=rsp_id_q, rsp_sum_o=adder_sum_i.
  - Latency is exactly 1 cycle from grant to response.
  - Back-to-back grants produce back-to-back responses.
- No response backpressure: a requester must capture the result in its rsp_valid_o cycle. The adder output persists when idle, but this is not guaranteed after a later grant.
- Arithmetic: no widening. Overflow wraps modulo 2^DATA_WIDTH_SUM (two's complement), as the adder does.
- busy_cnt_q increments on each grant and saturates at 16'hFFFF.
- Simultaneous events:
  - A requester may hold req_valid_i on the cycle it receives a response. The new request is arbitrated normally.
  - Dropping req_valid_i without a grant is legal (request withdrawn).

Optional Feature:
- Macro ADDER_ARB_LOCK_EN.
- Defined:
  - Adds lock_i and a lock counter.
  - If requester k was granted last cycle, lock_i[k]=1 and req_valid_i[k]=1, then k is granted again regardless of ptr_q, and ptr_q holds.
  - The lock counter increments per locked grant. After LOCK_MAX consecutive grants to k, lock is ignored for one arbitration and ptr_q advances to k+1.
  - The lock counter clears on any non-locked grant, on an idle cycle, and on reset.
- Undefined: lock_i is absent and arbitration is pure round-robin.

Test Plan:
- Single request: NUM_REQ=4, req_valid_i=4'b0100, summands 100 and -30 for one cycle. Expect req_ready_o=4'b0100 and adder_en_o=1. Next cycle: rsp_valid_o=4'b0100, rsp_id_o=2, rsp_sum_o=70; then ptr_q=3.
- All four requesters valid continuously for 8 cycles from reset. Expect grants in order 0,1,2,3,0,1,2,3 and responses with rsp_id_o in the same order one cycle later. busy_cnt_o=8.
- Wrap: ptr_q=3, req_valid_i=4'b1001. Expect grant to 3, then 0, then 3 alternating.
- Overflow: summands 20'h7FFFF + 1. Expect rsp_sum_o=20'h80000 (-524288).
- Reset mid-operation: grant to 1, then assert rst_i on the next edge. Expect rsp_valid_o=0 after the reset edge, busy_cnt_o=0 and ptr_q=0. The first post-reset grant with all requests valid goes to 0.
- ADDER_ARB_LOCK_EN, LOCK_MAX=3: requester 0 has lock and valid held high while requester 1 is valid. Expect grants 0,0,0,1,0,0,0,1,… with requester 1 never starved beyond LOCK_MAX cycles.
